// File: rtl/pulse_scheduler_pkg.sv
// Shared types and constants for the pulse scheduler: descriptor layout,
// FSM state encodings and a field-extraction helper.
package pulse_scheduler_pkg;

  localparam int DESC_W  = 64;
  localparam int DELAY_W = 12;

  // Layout of a pulse descriptor as issued by the quantum handler.
  typedef struct packed {
    logic [3:0]  qubit;
    logic [11:0] delay;
    logic [15:0] duration;
    logic [15:0] amp;
    logic [15:0] phase;
  } pulse_descriptor_t;

  // Scheduler FSM encodings, kept as plain constants for older tool flows.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  // Pull the inter-pulse delay out of a raw descriptor word.
  function automatic logic [DELAY_W-1:0] desc_delay(input logic [DESC_W-1:0] raw);
    pulse_descriptor_t d;
    d = pulse_descriptor_t'(raw);
    return d.delay;
  endfunction

endpackage

// File: rtl/pulse_fifo.sv
// Synchronous FIFO for pulse descriptors. Head entry is readable without a
// pop so the scheduler can latch it on the same edge it pops. Pushes that
// arrive while full are dropped and flagged with a sticky overflow bit.
module pulse_fifo
  import pulse_scheduler_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DESC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push_ok, pop_ok;

  // Status is decoded purely from the registered count.
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign overflow_o = overflow_q;
  assign rdata_o    = mem_q[rd_ptr_q];

  assign push_ok = push_valid_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A full-FIFO push is lost even if a pop frees a slot on the same edge.
    if (push_valid_i && full_o) overflow_d = 1'b1;
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Pulse scheduler: buffers descriptors, waits each one's programmed delay,
// then presents it to the pulse generator with a valid/ready handshake and
// a free-running cycle timestamp.
module pulse_scheduler
  import pulse_scheduler_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       pulse_descriptor,
  input  logic              pulse_descriptor_valid,
  output logic              pulse_register_full,
  output logic              pulse_register_empty,
  input  logic              run,
  output logic [63:0]       out_descriptor,
  output logic [TS_W-1:0]   out_timestamp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);

  logic [63:0]        fifo_rdata;
  logic               fifo_empty;
  logic               pop;
  logic               can_pop;

  logic [1:0]         state_q, state_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [63:0]        hold_q, hold_d;
  logic [TS_W-1:0]    ts_q;
  logic [63:0]        out_desc_q, out_desc_d;
  logic [TS_W-1:0]    out_ts_q, out_ts_d;
  logic               out_valid_q, out_valid_d;

  pulse_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (pulse_descriptor_valid),
    .wdata_i      (pulse_descriptor),
    .pop_i        (pop),
    .rdata_o      (fifo_rdata),
    .full_o       (pulse_register_full),
    .empty_o      (fifo_empty),
    .overflow_o   (overflow)
  );

  assign pulse_register_empty = fifo_empty;
  assign out_descriptor       = out_desc_q;
  assign out_timestamp        = out_ts_q;
  assign out_valid            = out_valid_q;

  assign can_pop = run && !fifo_empty;

  // Scheduler FSM: pop -> count down delay -> hold valid until accepted.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hold_d      = hold_q;
    out_desc_d  = out_desc_q;
    out_ts_d    = out_ts_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          hold_d  = fifo_rdata;
          dcnt_d  = desc_delay(fifo_rdata);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // run is deliberately ignored here: a popped pulse always goes out.
        if (dcnt_q == '0) begin
          out_desc_d  = hold_q;
          out_ts_d    = ts_q;
          out_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          dcnt_d = dcnt_q - DELAY_W'(1);
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (can_pop) begin
            pop     = 1'b1;
            hold_d  = fifo_rdata;
            dcnt_d  = desc_delay(fifo_rdata);
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, hold, delay counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dcnt_q      <= '0;
      hold_q      <= '0;
      out_desc_q  <= '0;
      out_ts_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hold_q      <= hold_d;
      out_desc_q  <= out_desc_d;
      out_ts_q    <= out_ts_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Free-running cycle timestamp, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler.
module tb_pulse_scheduler;

  logic        clk;
  logic        reset;
  logic [63:0] pulse_descriptor;
  logic        pulse_descriptor_valid;
  logic        pulse_register_full;
  logic        pulse_register_empty;
  logic        run;
  logic [63:0] out_descriptor;
  logic [31:0] out_timestamp;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] ts_model;
  logic [63:0] exp_q[$];

  pulse_scheduler #(.DEPTH(16), .TS_W(32)) u_dut (
    .clk                    (clk),
    .reset                  (reset),
    .pulse_descriptor       (pulse_descriptor),
    .pulse_descriptor_valid (pulse_descriptor_valid),
    .pulse_register_full    (pulse_register_full),
    .pulse_register_empty   (pulse_register_empty),
    .run                    (run),
    .out_descriptor         (out_descriptor),
    .out_timestamp          (out_timestamp),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .overflow               (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count since the last reset edge.
  always @(posedge clk) begin
    if (reset) ts_model <= 32'd0;
    else       ts_model <= ts_model + 32'd1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int q, input int dly, input int tag);
    mk = {4'(q), 12'(dly), 16'(tag), 16'(tag ^ 'hA5A5), 16'(tag * 3)};
  endfunction

  task automatic push(input logic [63:0] d);
    pulse_descriptor       = d;
    pulse_descriptor_valid = 1'b1;
    tick(1);
    pulse_descriptor_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (out_valid) ok = 1'b1;
  endtask

  initial begin
    bit          ok;
    logic [63:0] d;
    logic [63:0] z;
    int          seen;

    reset = 1'b1;
    pulse_descriptor = '0;
    pulse_descriptor_valid = 1'b0;
    run = 1'b0;
    out_ready = 1'b0;
    tick(3);
    reset = 1'b0;

    // Reset state and idle behaviour.
    chk("rst_desc", out_descriptor, 64'd0);
    chk("rst_ts", out_timestamp, 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_full", pulse_register_full, 1'b0);
      chk("idle_empty", pulse_register_empty, 1'b1);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_ovf", overflow, 1'b0);
    end

    // Single pulse, delay 5: valid exactly 7 edges after the push edge.
    run = 1'b1;
    out_ready = 1'b1;
    d = mk(3, 5, 16'h1234);
    push(d);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("lat_low", out_valid, 1'b0);
    end
    tick(1);
    chk("lat_high", out_valid, 1'b1);
    chk("lat_desc", out_descriptor, d);
    chk("lat_ts", out_timestamp, ts_model - 32'd1);
    tick(1);
    chk("lat_one_cycle", out_valid, 1'b0);

    // Fill with run=0, overflow on the 17th, then drain in order.
    run = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      d = mk(i, i % 3, 16'h100 + i);
      exp_q.push_back(d);
      push(d);
    end
    chk("fill_full", pulse_register_full, 1'b1);
    chk("fill_empty", pulse_register_empty, 1'b0);
    chk("fill_ovf0", overflow, 1'b0);
    push(mk(15, 0, 16'hDEAD));
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", u_dut.u_fifo.count_q, 64'd16);
    chk("ovf_full", pulse_register_full, 1'b1);
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_valid(20, ok);
      chk("drain_wait", ok, 1'b1);
      chk($sformatf("drain_desc%0d", i), out_descriptor, exp_q[i]);
      tick(1);
    end
    tick(10);
    chk("drain_empty", pulse_register_empty, 1'b1);
    chk("drain_novalid", out_valid, 1'b0);
    chk("drain_ovf_sticky", overflow, 1'b1);

    // Back-pressure: hold ready low for 20 cycles, then release.
    run = 1'b0;
    out_ready = 1'b0;
    push(mk(1, 2, 16'hAAAA));
    push(mk(2, 0, 16'hBBBB));
    run = 1'b1;
    wait_valid(20, ok);
    chk("stall_wait", ok, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_desc", out_descriptor, mk(1, 2, 16'hAAAA));
    end
    out_ready = 1'b1;
    tick(1);
    chk("hs_low", out_valid, 1'b0);
    tick(1);
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_desc", out_descriptor, mk(2, 0, 16'hBBBB));
    tick(1);
    chk("b2b_done", out_valid, 1'b0);
    run = 1'b0;

    // Push while full coinciding with an ISSUE pop.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst2_ovf", overflow, 1'b0);
    chk("rst2_empty", pulse_register_empty, 1'b1);
    run = 1'b1;
    out_ready = 1'b0;
    push(mk(0, 0, 16'h5000));
    wait_valid(10, ok);
    chk("full_pop_wait", ok, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      d = mk(i, i % 2, 16'h6000 + i);
      exp_q.push_back(d);
      push(d);
    end
    chk("fp_full", pulse_register_full, 1'b1);
    chk("fp_ovf0", overflow, 1'b0);
    z = mk(9, 0, 16'h7777);
    pulse_descriptor = z;
    pulse_descriptor_valid = 1'b1;
    out_ready = 1'b1;
    tick(1);
    pulse_descriptor_valid = 1'b0;
    chk("fp_ovf", overflow, 1'b1);
    chk("fp_count", u_dut.u_fifo.count_q, 64'd15);
    chk("fp_notfull", pulse_register_full, 1'b0);
    chk("fp_hs", out_valid, 1'b0);
    for (int i = 0; i < 16; i++) begin
      wait_valid(20, ok);
      chk("fp_drain_wait", ok, 1'b1);
      chk($sformatf("fp_desc%0d", i), out_descriptor, exp_q[i]);
      tick(1);
    end
    tick(5);
    chk("fp_end_empty", pulse_register_empty, 1'b1);
    chk("fp_end_novalid", out_valid, 1'b0);

    // Reset while waiting with three entries queued.
    run = 1'b0;
    push(mk(4, 100, 16'h8000));
    push(mk(5, 0, 16'h8001));
    push(mk(6, 0, 16'h8002));
    push(mk(7, 0, 16'h8003));
    run = 1'b1;
    tick(3);
    chk("rw_state_wait", u_dut.state_q, 64'(pulse_scheduler_pkg::ST_WAIT));
    chk("rw_count3", u_dut.u_fifo.count_q, 64'd3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rw_empty", pulse_register_empty, 1'b1);
    chk("rw_full", pulse_register_full, 1'b0);
    chk("rw_valid", out_valid, 1'b0);
    chk("rw_state_idle", u_dut.state_q, 64'(pulse_scheduler_pkg::ST_IDLE));
    chk("rw_ovf", overflow, 1'b0);
    chk("rw_desc", out_descriptor, 64'd0);
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (out_valid) seen++;
    end
    chk("rw_no_pulse", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
